// File: rtl/tb_mm_status_pkg.sv
// ---------------------------------------------------------------------------
// tb_mm_status_pkg
// Shared definitions for the core-to-testbench status responder:
//   - register offsets within the 32-byte window
//   - default pass magic for TEST_RESULT
//   - decoded register select enum and the word-index decoder
// No ports (package).
// ---------------------------------------------------------------------------
package tb_mm_status_pkg;

  localparam logic [4:0] PRINT_OFFS  = 5'h00;
  localparam logic [4:0] TEST_OFFS   = 5'h04;
  localparam logic [4:0] EXIT_OFFS   = 5'h08;
  localparam logic [4:0] CYCLE_OFFS  = 5'h0C;
  localparam logic [4:0] STATUS_OFFS = 5'h10;

  localparam logic [31:0] PASS_MAGIC_DEFAULT = 32'd123456789;

  typedef enum logic [2:0] {
    REG_PRINT,
    REG_TEST,
    REG_EXIT,
    REG_CYCLE,
    REG_STATUS,
    REG_NONE
  } reg_sel_e;

  // Maps address bits [4:2] to a register; unlisted words are REG_NONE.
  function automatic reg_sel_e decode_word(input logic [2:0] word);
    reg_sel_e sel;
    sel = REG_NONE;
    if (word == PRINT_OFFS[4:2])       sel = REG_PRINT;
    else if (word == TEST_OFFS[4:2])   sel = REG_TEST;
    else if (word == EXIT_OFFS[4:2])   sel = REG_EXIT;
    else if (word == CYCLE_OFFS[4:2])  sel = REG_CYCLE;
    else if (word == STATUS_OFFS[4:2]) sel = REG_STATUS;
    return sel;
  endfunction

endpackage

// File: rtl/tb_mm_char_fifo.sv
// ---------------------------------------------------------------------------
// tb_mm_char_fifo
// Small synchronous FIFO of 8-bit characters for the stdout channel.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write side (ignored when full)
//   pop             read side (ignored when empty)
//   head            oldest entry, 0 while empty
//   full, empty     registered-state flags
//   count           number of entries held
// DEPTH must be a power of two >= 2 so pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module tb_mm_char_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "tb_mm_char_fifo: DEPTH must be a power of two >= 2");
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Gate the head so the output reads 0 out of reset and when drained.
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tb_mm_status_responder.sv
// ---------------------------------------------------------------------------
// tb_mm_status_responder
// Device end of the core-to-testbench status channel on the core data bus.
// Decodes writes into pass/fail flags, an exit code and stdout characters,
// and serves a free-running cycle counter and a status word for reads.
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   data_req_i/data_gnt_o             request / combinational grant
//   data_addr_i, data_we_i,
//   data_be_i, data_wdata_i           request payload
//   data_rvalid_o, data_rdata_o       response, one cycle after each grant
//   stdout_valid_o, stdout_char_o,
//   stdout_ready_i                    stdout FIFO head, ready/valid drained
//   tests_passed_o, tests_failed_o    sticky test result flags
//   exit_valid_o, exit_value_o        sticky exit flag and latched code
// Optional build macro TB_MM_RANDOM_STALL_EN: an LFSR withholds grant on
// roughly one cycle in four to exercise the requester's stall path.
// ---------------------------------------------------------------------------
module tb_mm_status_responder
  import tb_mm_status_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] PASS_MAGIC = PASS_MAGIC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        stdout_valid_o,
  output logic [7:0]  stdout_char_o,
  input  logic        stdout_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             in_window;
  reg_sel_e         sel;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             stall;
  logic             wr_en;
  logic             rd_en;
  logic             push;
  logic             pop;
  logic [31:0]      rd_val;
  logic [31:0]      cycle_cnt;
  logic             unused_bits;

  // Sub-word address bits and upper byte enables carry no meaning here.
  assign unused_bits = ^{data_addr_i[1:0], data_be_i[3:1]};

  assign in_window = (data_addr_i[31:5] == BASE_ADDR[31:5]);
  assign sel       = in_window ? decode_word(data_addr_i[4:2]) : REG_NONE;

`ifdef TB_MM_RANDOM_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Full is registered state, so a same-cycle pop does not open the grant.
  assign data_gnt_o = data_req_i && !stall &&
                      !(sel == REG_PRINT && data_we_i && fifo_full);

  assign wr_en = data_gnt_o && data_we_i;
  assign rd_en = data_gnt_o && !data_we_i;
  assign push  = wr_en && (sel == REG_PRINT) && data_be_i[0];
  assign pop   = stdout_valid_o && stdout_ready_i;

  assign stdout_valid_o = !fifo_empty;

  always_comb begin
    rd_val = '0;
    case (sel)
      REG_CYCLE:  rd_val = cycle_cnt;
      REG_STATUS: rd_val = {16'b0, 8'(fifo_count), 5'b0,
                            exit_valid_o, tests_failed_o, tests_passed_o};
      default:    rd_val = '0;
    endcase
  end

  tb_mm_char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (data_wdata_i[7:0]),
    .pop       (pop),
    .head      (stdout_char_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_cnt      <= '0;
      data_rvalid_o  <= 1'b0;
      data_rdata_o   <= '0;
      tests_passed_o <= 1'b0;
      tests_failed_o <= 1'b0;
      exit_valid_o   <= 1'b0;
      exit_value_o   <= '0;
    end else begin
      cycle_cnt     <= cycle_cnt + 1'b1;
      data_rvalid_o <= data_gnt_o;
      data_rdata_o  <= rd_en ? rd_val : 32'h0;

      // First TEST_RESULT write decides the outcome for the whole run.
      if (wr_en && sel == REG_TEST && !tests_passed_o && !tests_failed_o) begin
        if (data_wdata_i == PASS_MAGIC) tests_passed_o <= 1'b1;
        else                            tests_failed_o <= 1'b1;
      end

      if (wr_en && sel == REG_EXIT && !exit_valid_o) begin
        exit_valid_o <= 1'b1;
        exit_value_o <= data_wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_tb_mm_status_responder.sv
// ---------------------------------------------------------------------------
// tb_tb_mm_status_responder
// Directed self-checking bench for tb_mm_status_responder (default build).
// Inputs change 1 ns after the rising edge; combinational grant is sampled on
// the falling edge, registered outputs 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_tb_mm_status_responder;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam logic [31:0] MAGIC = 32'd123456789;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        so_valid;
  logic [7:0]  so_char;
  logic        so_ready;
  logic        passed;
  logic        failed;
  logic        exit_valid;
  logic [31:0] exit_value;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tb_mm_status_responder dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .data_req_i     (req),
    .data_gnt_o     (gnt),
    .data_addr_i    (addr),
    .data_we_i      (we),
    .data_be_i      (be),
    .data_wdata_i   (wdata),
    .data_rvalid_o  (rvalid),
    .data_rdata_o   (rdata),
    .stdout_valid_o (so_valid),
    .stdout_char_o  (so_char),
    .stdout_ready_i (so_ready),
    .tests_passed_o (passed),
    .tests_failed_o (failed),
    .exit_valid_o   (exit_valid),
    .exit_value_o   (exit_value)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    req   = 1'b0;
    we    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    be    = 4'h0;
  endtask

  // One granted transfer; starts 1 ns after a rising edge, returns likewise.
  task automatic bus_xfer(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          output logic [31:0] rd);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    be    = b;
    @(negedge clk);
    check({tag, "_gnt"}, 32'(gnt), 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    rd = rdata;
    idle_bus();
  endtask

  task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus_xfer(tag, 1'b1, a, d, 4'hF, r);
    check({tag, "_wrdata0"}, r, 32'h0);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, output logic [31:0] r);
    bus_xfer(tag, 1'b0, a, 32'h0, 4'hF, r);
  endtask

  logic [31:0] r1;
  logic [31:0] r2;
  logic [7:0]  exp_chars [8];

  initial begin
    rst      = 1'b1;
    so_ready = 1'b0;
    idle_bus();
    exp_chars = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rvalid",   32'(rvalid),     32'd0);
    check("rst_rdata",    rdata,           32'h0);
    check("rst_so_valid", 32'(so_valid),   32'd0);
    check("rst_so_char",  32'(so_char),    32'd0);
    check("rst_passed",   32'(passed),     32'd0);
    check("rst_failed",   32'(failed),     32'd0);
    check("rst_exit_v",   32'(exit_valid), 32'd0);
    check("rst_exit_val", exit_value,      32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_gnt", 32'(gnt), 32'd0);
    @(posedge clk);
    #1;

    // Unmapped accesses: granted, responded, read 0, no side effects
    rd("unm_1c", BASE + 32'h1C, r1);
    check("unm_1c_rdata", r1, 32'h0);
    rd("unm_3000", 32'h3000_0000, r1);
    check("unm_3000_rdata", r1, 32'h0);
    rd("unm_cyc_outside", 32'h2000_002C, r1);
    check("unm_cyc_outside_rdata", r1, 32'h0);
    wr("unm_w_print", 32'h3000_0000, 32'h51);
    wr("unm_w_14", BASE + 32'h14, 32'h52);
    check("unm_no_push", 32'(so_valid), 32'd0);
    rd("unm_status", BASE + 32'h10, r1);
    check("unm_status_rdata", r1, 32'h0);

    // Mid-run reset clears exit state, FIFO and counter
    wr("exit5", BASE + 32'h08, 32'd5);
    check("exit5_valid", 32'(exit_valid), 32'd1);
    check("exit5_value", exit_value,      32'd5);
    req = 1'b1; we = 1'b1; addr = BASE; wdata = 32'h5A; be = 4'hF;
    @(negedge clk);
    check("print_z_gnt",     32'(gnt),      32'd1);
    check("print_z_nobypass", 32'(so_valid), 32'd0);
    @(posedge clk);
    #1;
    idle_bus();
    check("print_z_valid", 32'(so_valid), 32'd1);
    check("print_z_char",  32'(so_char),  32'h5A);
    rst = 1'b1;
    #1;
    check("arst_exit_v",   32'(exit_valid), 32'd0);
    check("arst_exit_val", exit_value,      32'h0);
    check("arst_so_valid", 32'(so_valid),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd("cyc_after_rst", BASE + 32'h0C, r1);
    check("cyc_after_rst_small", 32'(r1 < 32'd4), 32'd1);

    // First TEST_RESULT write of a non-magic value fails the run
    wr("test_fail1", BASE + 32'h04, 32'd1);
    check("test_fail1_failed", 32'(failed), 32'd1);
    check("test_fail1_passed", 32'(passed), 32'd0);
    wr("test_fail_magic", BASE + 32'h04, MAGIC);
    check("test_fail_magic_passed", 32'(passed), 32'd0);

    // Fresh run: magic passes, later write is ignored
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst2_failed", 32'(failed), 32'd0);
    req = 1'b1; we = 1'b1; addr = BASE + 32'h04; wdata = MAGIC; be = 4'hF;
    @(negedge clk);
    check("test_pass_gnt", 32'(gnt), 32'd1);
    check("test_pass_pre", 32'(passed), 32'd0);
    @(posedge clk);
    #1;
    idle_bus();
    check("test_pass_passed", 32'(passed), 32'd1);
    wr("test_pass_then1", BASE + 32'h04, 32'd1);
    check("test_pass_then1_failed", 32'(failed), 32'd0);
    check("test_pass_then1_passed", 32'(passed), 32'd1);

    // CYCLE back-to-back reads
    req = 1'b1; we = 1'b0; addr = BASE + 32'h0C; be = 4'hF;
    @(negedge clk);
    check("b2b_gnt0", 32'(gnt), 32'd1);
    @(posedge clk);
    #1;
    check("b2b_rvalid0", 32'(rvalid), 32'd1);
    r1 = rdata;
    @(negedge clk);
    check("b2b_gnt1", 32'(gnt), 32'd1);
    @(posedge clk);
    #1;
    check("b2b_rvalid1", 32'(rvalid), 32'd1);
    r2 = rdata;
    idle_bus();
    check("b2b_delta", r2 - r1, 32'd1);
    @(posedge clk);
    #1;
    check("b2b_rvalid_drop", 32'(rvalid), 32'd0);
    check("b2b_rdata_zero",  rdata,       32'h0);

    // STATUS with three queued characters and passed set
    wr("print_x", BASE, 32'h78);
    wr("print_y", BASE, 32'h79);
    wr("print_z", BASE, 32'h7A);
    rd("status3", BASE + 32'h10, r1);
    check("status3_rdata", r1, 32'h0000_0301);
    so_ready = 1'b1;
    check("drain_x", 32'(so_char), 32'h78);
    @(posedge clk); #1;
    check("drain_y", 32'(so_char), 32'h79);
    @(posedge clk); #1;
    check("drain_z", 32'(so_char), 32'h7A);
    @(posedge clk); #1;
    so_ready = 1'b0;
    check("drain_empty", 32'(so_valid), 32'd0);
    begin
      logic [31:0] rtmp;
      bus_xfer("print_nobe0", 1'b1, BASE, 32'h4B, 4'hE, rtmp);
    end
    check("print_nobe0_nopush", 32'(so_valid), 32'd0);

    // EXIT first write wins
    wr("exit_2a", BASE + 32'h08, 32'h0000_002A);
    wr("exit_0",  BASE + 32'h08, 32'h0);
    check("exit_valid", 32'(exit_valid), 32'd1);
    check("exit_value", exit_value,      32'h0000_002A);

    // Fill FIFO, ninth write stalls until a pop
    for (int i = 0; i < 8; i++) wr("fill", BASE, 32'h41 + 32'(i));
    rd("status_full", BASE + 32'h10, r1);
    check("status_full_rdata", r1, 32'h0000_0805);
    req = 1'b1; we = 1'b1; addr = BASE; wdata = 32'h49; be = 4'hF;
    so_ready = 1'b1;
    @(negedge clk);
    check("ninth_gnt_full", 32'(gnt), 32'd0);
    check("head_a", 32'(so_char), 32'h41);
    @(posedge clk);
    #1;
    so_ready = 1'b0;
    check("ninth_no_rvalid", 32'(rvalid), 32'd0);
    @(negedge clk);
    check("ninth_gnt_after_pop", 32'(gnt), 32'd1);
    @(posedge clk);
    #1;
    idle_bus();
    check("ninth_rvalid", 32'(rvalid), 32'd1);
    so_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 32'(so_valid), 32'd1);
      check("drain_char",  32'(so_char),  32'(exp_chars[i]));
      @(posedge clk);
      #1;
    end
    so_ready = 1'b0;
    check("drain_done", 32'(so_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tb_mm_status_responder.md
Name: tb_mm_status_responder

Overview:
- Memory-mapped responder on the core data bus inside the simulation wrapper; it is the device end of the core-to-testbench status channel.
- Decodes core writes into test pass/fail, program exit code and stdout characters.
- Drives the tests_passed/tests_failed/exit_valid/exit_value signals that the testbench top watches to finish simulation.
- Buffers stdout characters in a small FIFO drained by a ready/valid consumer (testbench printer).

Parameters:
- BASE_ADDR, 32'h2000_0000, base of the 32-byte register window.
- FIFO_DEPTH, 8, stdout FIFO entries; power of two, ≥2.
- PASS_MAGIC, 32'd123456789, TEST_RESULT write value meaning pass.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active high
- data_req_i  in  1  bus request
- data_gnt_o  out  1  grant (combinational)
- data_addr_i  in  32  byte address
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables
- data_wdata_i  in  32  write data
- data_rvalid_o  out  1  response valid
- data_rdata_o  out  32  read data
- stdout_valid_o  out  1  FIFO head valid
- stdout_char_o  out  8  FIFO head character
- stdout_ready_i  in  1  consumer accepts head
- tests_passed_o  out  1  sticky pass flag
- tests_failed_o  out  1  sticky fail flag
- exit_valid_o  out  1  sticky exit flag
- exit_value_o  out  32  latched exit code

Behaviour:
- Reset: rst_i asserted at any time clears all state asynchronously.
  - All outputs go to 0.
  - FIFO is emptied, cycle counter is cleared, any pending response is dropped.
- Register map (offset from BASE_ADDR):
  - 0x00 PRINT (W): pushes wdata[7:0].
  - 0x04 TEST_RESULT (W).
  - 0x08 EXIT (W).
  - 0x0C CYCLE (R): free-running 32-bit counter, increments every cycle after reset, wraps 0xFFFF_FFFF→0.
  - 0x10 STATUS (R): {16'b0, 8'(fifo count), 5'b0, exit_valid, failed, passed}.
- Decode uses address bits [4:2]. Any address outside the window, or an unlisted offset, is unmapped.
- Unmapped reads return 0. Unmapped writes are ignored. Both are still granted and responded to.
- Grant: data_gnt_o = data_req_i, except when a PRINT write arrives while the FIFO is full.
  - The full check uses registered state. A pop in the same cycle does not unblock the grant; it is granted the next cycle.
- Response: data_rvalid_o is asserted exactly 1 cycle after each grant.
  - Back-to-back grants give back-to-back rvalid.
  - data_rdata_o holds the read value captured at grant; it is 0 for writes and whenever rvalid is low.
- Write side effects happen at the grant edge.
  - Byte enables are ignored, except PRINT, which requires be[0]. A PRINT write with be[0]=0 is granted but pushes nothing.
- TEST_RESULT:
  - Value == PASS_MAGIC sets tests_passed_o; any other value sets tests_failed_o.
  - The first write wins: once either flag is set, later TEST_RESULT writes are ignored.
- EXIT: the first write sets exit_valid_o and latches exit_value_o; later EXIT writes are ignored.
- Flags assert the cycle after the grant and stay set until reset.
- FIFO:
  - stdout_valid_o = count != 0. A pop occurs when stdout_valid_o && stdout_ready_i.
  - Push and pop in the same cycle leave the count unchanged.
  - A push into an empty FIFO is visible at the head the following cycle; there is no bypass.
  - Pointers wrap modulo FIFO_DEPTH.
- Elaboration-time check: FIFO_DEPTH is a power of two, else $fatal.

Optional Feature:
- Macro: TB_MM_RANDOM_STALL_EN.
- Defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) steps every cycle.
  - Grant is additionally withheld when lfsr[1:0]==2'b00, which stresses the core's LSU stall path.
  - The FIFO-full rule still applies.
- Undefined: the LFSR is absent, and grant depends only on req and the FIFO-full rule.

Decomposition:
- Package tb_mm_status_pkg holds:
  - Register offsets: PRINT_OFFS, TEST_OFFS, EXIT_OFFS, CYCLE_OFFS, STATUS_OFFS.
  - Default PASS_MAGIC.
  - An enum for decoded register select (REG_PRINT, REG_TEST, REG_EXIT, REG_CYCLE, REG_STATUS, REG_NONE).
- One sub-module: tb_mm_char_fifo (parameterised depth, 8-bit data, push/pop/full/empty/count).

Test Plan:
- Reset mid-run: write EXIT=5, pulse rst_i for 1 cycle → exit_valid_o=0, exit_value_o=0, FIFO empty, CYCLE read restarts from a small value.
- TEST_RESULT=123456789 → tests_passed_o=1 on the cycle after the grant. A subsequent write of 1 leaves tests_failed_o=0. In a fresh run, a first write of 1 sets tests_failed_o=1.
- EXIT=0x0000_002A then EXIT=0 → exit_valid_o=1, exit_value_o=0x2A held; rvalid asserted 1 cycle after each grant.
- Fill FIFO with "ABCDEFGH" while stdout_ready_i=0:
  - The 9th PRINT write sees gnt=0.
  - Raise ready for 1 cycle → 'A' pops and the 9th write is granted the next cycle.
  - Drain order is A..H, then the 9th character.
- Read CYCLE twice back-to-back → values differ by exactly 1. Read STATUS with 3 characters queued and passed set → 0x0000_0301.
- Unmapped read at BASE_ADDR+0x1C and at 0x3000_0000 → granted, rvalid after 1 cycle, rdata=0, no state change.
